// File: rtl/gr_pkg.sv
// Shared definitions for the guess-number round sequencer, display mux and LED driver.
package gr_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StWin   = 3'd4,
        StLose  = 3'd5
    } gr_state_e;

    // Encoding of lose_cause.
    localparam logic LOSE_TIMEOUT = 1'b0;
    localparam logic LOSE_TRIES   = 1'b1;

    // WIN and LOSE both show the result for a fixed hold time.
    function automatic logic is_hold_state(input gr_state_e s);
        return (s == StWin) || (s == StLose);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Result-display hold timer: cleared on entry, counts while enabled, flags the last cycle.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 300_000_000,
    parameter int unsigned HOLD_W      = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over counting so the first hold cycle reads zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + HOLD_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer: drives the countdown timer, gates guesses, counts tries, decides win/lose.
module guess_round_ctrl
    import gr_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = 8,
    parameter int unsigned TRY_W       = 4,
    parameter int unsigned HOLD_CYCLES = 300_000_000,
    parameter int unsigned HOLD_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               guess_valid,
    input  logic               guess_hit,
    input  logic               timer_finish,
    output logic               timer_set,
    output logic               timer_en,
    output logic               new_secret,
    output logic [STATE_W-1:0] state,
    output logic [TRY_W-1:0]   tries_used,
    output logic [TRY_W-1:0]   tries_left,
    output logic               win,
    output logic               lose,
    output logic               lose_cause
);

    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    gr_state_e        state_q, state_d;
    logic [TRY_W-1:0] tries_used_q, tries_used_d;
    logic             lose_cause_q, lose_cause_d;
    logic [TRY_W-1:0] tries_inc;
    logic             hold_load;
    logic             hold_en;
    logic             hold_done;

    assign tries_inc = (tries_used_q >= TRY_MAX) ? TRY_MAX : tries_used_q + TRY_W'(1);

    // Hold timer restarts whenever WIN/LOSE is entered from a non-hold state.
    assign hold_load = is_hold_state(state_d) && !is_hold_state(state_q);
    assign hold_en   = is_hold_state(state_q);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (hold_load),
        .en_i   (hold_en),
        .done_o (hold_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Attempt counter and lose-cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tries_used_q <= '0;
            lose_cause_q <= LOSE_TIMEOUT;
        end else begin
            tries_used_q <= tries_used_d;
            lose_cause_q <= lose_cause_d;
        end
    end

    // Next-state and counter update; guess accounting happens before the state decision.
    always_comb begin
        state_d      = state_q;
        tries_used_d = tries_used_q;
        lose_cause_d = lose_cause_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (start) begin
                    state_d = StLoad;
                end else begin
                    if (guess_valid) begin
                        tries_used_d = tries_inc;
                    end
                    if (guess_valid && guess_hit) begin
                        state_d = StWin;
                    end else if (guess_valid && (tries_inc == TRY_MAX)) begin
                        state_d      = StLose;
                        lose_cause_d = LOSE_TRIES;
                    end else if (timer_finish) begin
                        state_d      = StLose;
                        lose_cause_d = LOSE_TIMEOUT;
                    end else if (pause) begin
                        state_d = StPause;
                    end
                end
            end
            StPause: begin
                if (start) begin
                    state_d = StLoad;
                end else if (pause) begin
                    state_d = StRun;
                end
            end
            StWin, StLose: begin
                if (start) begin
                    state_d = StLoad;
                end else if (hold_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Every new round starts from zero attempts, visible already during LOAD.
        if (state_d == StLoad) begin
            tries_used_d = '0;
        end
    end

    // Moore outputs decoded from registered state and counters.
    always_comb begin
        timer_set  = (state_q == StLoad);
        new_secret = (state_q == StLoad);
        timer_en   = (state_q == StRun);
        win        = (state_q == StWin);
        lose       = (state_q == StLose);
        lose_cause = lose_cause_q;
        state      = state_q;
        tries_used = tries_used_q;
        tries_left = TRY_MAX - tries_used_q;
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Self-checking bench for guess_round_ctrl: directed round scenarios plus random pulses.
module tb_guess_round_ctrl;

    localparam int MAXT = 3;
    localparam int HOLD = 20;

    // Reference state codes.
    localparam int IDLE = 0, LOAD = 1, RUN = 2, PAUSE = 3, WIN = 4, LOSE = 5;

    logic       clk = 1'b0;
    logic       rst, start, pause, guess_valid, guess_hit, timer_finish;
    logic       timer_set, timer_en, new_secret, win, lose, lose_cause;
    logic [2:0] state;
    logic [3:0] tries_used, tries_left;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: round state, attempts, cause and cycles of hold remaining.
    int m_state = IDLE;
    int m_tries = 0;
    int m_cause = 0;
    int m_hold  = 0;

    always #5 clk = ~clk;

    guess_round_ctrl #(
        .MAX_TRIES   (MAXT),
        .TRY_W       (4),
        .HOLD_CYCLES (HOLD),
        .HOLD_W      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause        (pause),
        .guess_valid  (guess_valid),
        .guess_hit    (guess_hit),
        .timer_finish (timer_finish),
        .timer_set    (timer_set),
        .timer_en     (timer_en),
        .new_secret   (new_secret),
        .state        (state),
        .tries_used   (tries_used),
        .tries_left   (tries_left),
        .win          (win),
        .lose         (lose),
        .lose_cause   (lose_cause)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic enter(input int s);
        if (s == LOAD) m_tries = 0;
        if ((s == WIN || s == LOSE) && m_state != WIN && m_state != LOSE) m_hold = HOLD;
        m_state = s;
    endtask

    // Advance the model by one clock according to the round rules.
    task automatic model_step(input bit r, input bit st, input bit pa, input bit gv,
                              input bit gh, input bit tf);
        if (r) begin
            m_state = IDLE; m_tries = 0; m_cause = 0; m_hold = 0;
            return;
        end
        case (m_state)
            IDLE:  if (st) enter(LOAD);
            LOAD:  enter(RUN);
            RUN: begin
                if (st) begin
                    enter(LOAD);
                end else begin
                    if (gv && m_tries < MAXT) m_tries++;
                    if (gv && gh) enter(WIN);
                    else if (gv && m_tries == MAXT) begin m_cause = 1; enter(LOSE); end
                    else if (tf) begin m_cause = 0; enter(LOSE); end
                    else if (pa) enter(PAUSE);
                end
            end
            PAUSE: if (st) enter(LOAD); else if (pa) enter(RUN);
            WIN, LOSE: begin
                if (st) begin
                    enter(LOAD);
                end else begin
                    m_hold--;
                    if (m_hold == 0) m_state = IDLE;
                end
            end
            default: m_state = IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state",      int'(state),      m_state);
        check("tries_used", int'(tries_used), m_tries);
        check("tries_left", int'(tries_left), MAXT - m_tries);
        check("timer_set",  int'(timer_set),  int'(m_state == LOAD));
        check("new_secret", int'(new_secret), int'(m_state == LOAD));
        check("timer_en",   int'(timer_en),   int'(m_state == RUN));
        check("win",        int'(win),        int'(m_state == WIN));
        check("lose",       int'(lose),       int'(m_state == LOSE));
        if (m_state == LOSE) check("lose_cause", int'(lose_cause), m_cause);
    endtask

    // One clock: drive inputs, step the model, sample just after the edge.
    task automatic cyc(input bit r, input bit st, input bit pa, input bit gv,
                       input bit gh, input bit tf);
        rst = r; start = st; pause = pa; guess_valid = gv; guess_hit = gh; timer_finish = tf;
        model_step(r, st, pa, gv, gh, tf);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; pause = 0; guess_valid = 0; guess_hit = 0; timer_finish = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_lose_cause", int'(lose_cause), 0);

        // Start a round: one LOAD cycle, then RUN.
        cyc(0, 1, 0, 0, 0, 0);
        check("load_pulse", int'(timer_set & new_secret), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("run_tries_left", int'(tries_left), 3);

        // Two misses then a hit, then hold for exactly HOLD cycles.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        check("win_state", int'(state), WIN);
        check("win_tries", int'(tries_used), 3);
        n = 1;
        while (state == 3'(WIN) && n < 100) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (state == 3'(WIN)) n++;
        end
        check("win_hold_len", n, HOLD);
        check("after_hold", int'(state), IDLE);

        // Three misses exhaust the round; a further guess is ignored.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        check("exhaust_cause", int'(lose_cause), 1);
        check("exhaust_left", int'(tries_left), 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("extra_guess", int'(tries_used), 3);
        idle_n(HOLD + 2);

        // Timeout alone loses with cause 0; a hit coinciding with timeout wins.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("timeout_cause", int'(lose & ~lose_cause), 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        check("hit_at_timeout", int'(win), 1);
        // A non-exhausting miss at timeout still loses on time.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        check("miss_at_timeout", int'(tries_used), 1);

        // Pause ignores guesses and timeout.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("paused_en", int'(timer_en), 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("paused_state", int'(state), PAUSE);
        cyc(0, 0, 1, 0, 0, 0);
        check("resume", int'(state), RUN);

        // Reset during PAUSE with two tries used.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("pre_rst_tries", int'(tries_used), 2);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_pulses", int'(timer_set | new_secret | win | lose | timer_en), 0);

        // Abort from RUN restarts with a LOAD pulse and cleared tries.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("abort_load", int'(timer_set), 1);
        check("abort_tries", int'(tries_used), 0);

        // Random pulse traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 14) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
